// File: rtl/iob_uart_lite.sv
// iob_uart_lite: memory-mapped 8N1 UART slave on the IOb-native bus.
// CSR file, bit-timed transmitter and mid-bit-sampling receiver with a 1-byte holding register.
module iob_uart_lite #(
  parameter int          ADDR_W  = 3,
  parameter int          DATA_W  = 32,
  parameter logic [15:0] DIV_RST = 16'd868
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                txd,
  input  logic                rxd
);

  localparam logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DIV       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(7);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic [15:0]       div_q, div_d;
  logic              txen_q, txen_d;
  logic              rxen_q, rxen_d;
  logic              rx_ready_q, rx_ready_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        rx_hold_q, rx_hold_d;

  tx_state_t         tx_state_q, tx_state_d;
  logic [15:0]       tx_cnt_q, tx_cnt_d;
  logic [15:0]       tx_period_q, tx_period_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic              txd_q, txd_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_byte_q, tx_byte_d;

  rx_state_t         rx_state_q, rx_state_d;
  logic [15:0]       rx_cnt_q, rx_cnt_d;
  logic [15:0]       rx_period_q, rx_period_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic              rxd_s1_q, rxd_s1_d;
  logic              rxd_s2_q, rxd_s2_d;
  logic              rxd_prev_q, rxd_prev_d;

  logic              wr_en, rd_en, soft_rst, rd_rxdata;
  logic              tx_idle, tx_accept, tx_bit_end;
  logic              rx_fall, rx_load;
  logic [15:0]       div_eff, rx_half;
  logic [DATA_W-1:0] rd_word;
  logic              unused_wdata;

  assign wr_en        = valid && (wstrb != '0);
  assign rd_en        = valid && (wstrb == '0);
  assign soft_rst     = wr_en && (address == A_SOFTRESET) && wdata[0];
  assign rd_rxdata    = rd_en && (address == A_RXDATA);
  assign div_eff      = (div_q < 16'd2) ? 16'd2 : div_q;
  // A pending start counts as busy so a back-to-back TXDATA write cannot slip in.
  assign tx_idle      = (tx_state_q == TX_IDLE) && !tx_start_q;
  assign tx_accept    = wr_en && (address == A_TXDATA) && txen_q && tx_idle;
  assign tx_bit_end   = (tx_cnt_q == tx_period_q - 16'd1);
  assign rx_fall      = rxd_prev_q && !rxd_s2_q;
  assign rx_half      = rx_period_q >> 1;
  assign unused_wdata = ^wdata[DATA_W-1:16];

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign txd   = txd_q;

  always_comb begin
    rd_word = '0;
    case (address)
      A_DIV:     rd_word[15:0] = div_q;
      A_TXEN:    rd_word[0]    = txen_q;
      A_TXREADY: rd_word[0]    = tx_idle;
      A_RXDATA:  rd_word[7:0]  = rx_hold_q;
      A_RXEN:    rd_word[0]    = rxen_q;
      A_RXREADY: rd_word[1:0]  = {overrun_q, rx_ready_q};
      default:   rd_word       = '0;
    endcase
  end

  always_comb begin
    ready_d    = valid;
    rdata_d    = rdata_q;
    div_d      = div_q;
    txen_d     = txen_q;
    rxen_d     = rxen_q;
    rx_ready_d = rx_ready_q;
    overrun_d  = overrun_q;
    rx_hold_d  = rx_hold_q;
    if (rd_en) rdata_d = rd_word;
    if (wr_en) begin
      case (address)
        A_DIV:   div_d  = wdata[15:0];
        A_TXEN:  txen_d = wdata[0];
        A_RXEN:  rxen_d = wdata[0];
        default: ;
      endcase
    end
    if (rd_rxdata) begin
      rx_ready_d = 1'b0;
      overrun_d  = 1'b0;
    end
    // A read racing a new byte wins the overrun flag but not rx_ready.
    if (rx_load) begin
      rx_hold_d  = rx_shift_q;
      rx_ready_d = 1'b1;
      overrun_d  = rx_ready_q && !rd_rxdata;
    end
    if (soft_rst) begin
      rx_ready_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_period_d = tx_period_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    txd_d       = txd_q;
    tx_start_d  = tx_start_q;
    tx_byte_d   = tx_byte_q;
    if (tx_accept) begin
      tx_start_d = 1'b1;
      tx_byte_d  = wdata[7:0];
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start_q) begin
          tx_start_d  = 1'b0;
          tx_state_d  = TX_START;
          txd_d       = 1'b0;
          tx_cnt_d    = '0;
          tx_period_d = div_eff;
          tx_shift_d  = tx_byte_q;
          tx_bit_d    = '0;
        end
      end
      default: begin
        if (tx_bit_end) begin
          // The divisor is re-latched only here, so a DIV write never stretches a bit in flight.
          tx_cnt_d    = '0;
          tx_period_d = div_eff;
          case (tx_state_q)
            TX_START: begin
              tx_state_d = TX_DATA;
              txd_d      = tx_shift_q[0];
            end
            TX_DATA: begin
              if (tx_bit_q == 3'd7) begin
                tx_state_d = TX_STOP;
                txd_d      = 1'b1;
              end else begin
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_shift_d = tx_shift_q >> 1;
                txd_d      = tx_shift_q[1];
              end
            end
            default: begin
              tx_state_d = TX_IDLE;
              txd_d      = 1'b1;
            end
          endcase
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
    endcase
    if (soft_rst) begin
      tx_state_d = TX_IDLE;
      tx_start_d = 1'b0;
      tx_cnt_d   = '0;
      txd_d      = 1'b1;
    end
  end

  always_comb begin
    rxd_s1_d   = rxd;
    rxd_s2_d   = rxd_s1_q;
    rxd_prev_d = rxd_s2_q;
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_period_d = rx_period_q;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_load     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxen_q && rx_fall) begin
          rx_state_d  = RX_START;
          rx_cnt_d    = '0;
          rx_period_d = div_eff;
        end
      end
      RX_START: begin
        // Mid-start-bit resample: a line already back high was only a glitch.
        if (rx_cnt_q == rx_half - 16'd1) begin
          rx_cnt_d    = '0;
          rx_period_d = div_eff;
          rx_bit_d    = '0;
          rx_state_d  = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_period_q - 16'd1) begin
          rx_cnt_d    = '0;
          rx_period_d = div_eff;
          rx_shift_d  = {rxd_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: begin
        if (rx_cnt_q == rx_period_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_load    = rxd_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
    endcase
    if (soft_rst) begin
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      div_q      <= DIV_RST;
      txen_q     <= 1'b0;
      rxen_q     <= 1'b0;
      rx_ready_q <= 1'b0;
      overrun_q  <= 1'b0;
      rx_hold_q  <= '0;
    end else begin
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      div_q      <= div_d;
      txen_q     <= txen_d;
      rxen_q     <= rxen_d;
      rx_ready_q <= rx_ready_d;
      overrun_q  <= overrun_d;
      rx_hold_q  <= rx_hold_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_period_q <= 16'd2;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      txd_q       <= 1'b1;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_period_q <= tx_period_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      txd_q       <= txd_d;
      tx_start_q  <= tx_start_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_period_q <= 16'd2;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_period_q <= rx_period_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rxd_s1_q    <= rxd_s1_d;
      rxd_s2_q    <= rxd_s2_d;
      rxd_prev_q  <= rxd_prev_d;
    end
  end

endmodule

// File: tb/tb_iob_uart_lite.sv
// Scoreboard testbench for iob_uart_lite: bus reads are queued with expected data
// and checked by a monitor on ready; serial waveforms are checked per cycle.
module tb_iob_uart_lite;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        txd;
  logic        rxd;
  logic        rxd_drv;
  logic        loop_en;
  logic        valid_sampled;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic        sb_read_q[$];
  logic [31:0] sb_exp_q[$];
  string       sb_name_q[$];

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  iob_uart_lite #(
    .ADDR_W(3),
    .DATA_W(32),
    .DIV_RST(16'd868)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .address(address),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .ready(ready),
    .txd(txd),
    .rxd(rxd)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus transaction, issued at a falling edge; the expectation goes to the scoreboard.
  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [31:0] exp,
                               input string name);
    sb_read_q.push_back(strb == 4'h0);
    sb_exp_q.push_back(exp);
    sb_name_q.push_back(name);
    valid   = 1'b1;
    address = addr;
    wdata   = data;
    wstrb   = strb;
    @(negedge clk);
    valid = 1'b0;
    wstrb = 4'h0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    applyStimulus(addr, data, 4'hF, 32'd0, "write");
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(addr, 32'd0, 4'h0, exp, name);
  endtask

  task automatic check_frame(input logic [9:0] pat, input int div, input string name);
    for (int i = 0; i < 10 * div; i++) begin
      checkOutput(name, {31'd0, txd}, {31'd0, pat[i / div]});
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input logic [7:0] data, input logic stop, input int div);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frame[i];
      repeat (div) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) valid_sampled <= 1'b0;
    else     valid_sampled <= valid;
  end

  // Monitor: ready must follow each sampled request by exactly one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ready || valid_sampled)
        checkOutput("ready_timing", {31'd0, ready}, {31'd0, valid_sampled});
      if (ready) begin
        if (sb_read_q.size() == 0) begin
          total_cnt++;
          bad_cnt++;
          $display("[TB] FAIL spurious_ready: got ready with empty scoreboard at %0t", $time);
        end else begin
          logic        is_rd;
          logic [31:0] exp;
          string       nm;
          is_rd = sb_read_q.pop_front();
          exp   = sb_exp_q.pop_front();
          nm    = sb_name_q.pop_front();
          if (is_rd) checkOutput(nm, rdata, exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    address = '0;
    wdata   = '0;
    wstrb   = '0;
    rxd_drv = 1'b1;
    loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_txd", {31'd0, txd}, 32'd1);
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    bus_read(3'd1, 32'd868, "reset_div");
    bus_read(3'd4, 32'h1, "reset_txready");
    bus_read(3'd7, 32'h0, "reset_rxready");
    bus_read(3'd3, 32'h0, "reset_txen");
    bus_read(3'd6, 32'h0, "reset_rxen");
    bus_read(3'd0, 32'h0, "unused_softreset_read");
    bus_read(3'd2, 32'h0, "unused_txdata_read");
    bus_write(3'd4, 32'h0);
    bus_read(3'd4, 32'h1, "ro_write_ignored");

    // TX frame 0xA5 at DIV=4 with a dropped mid-frame write
    bus_write(3'd1, 32'hFFFF_0004);
    bus_read(3'd1, 32'd4, "div_upper_ignored");
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, 32'h1, "txen_set");
    bus_write(3'd2, 32'h0000_00A5);
    fork
      check_frame(10'b1101001010, 4, "tx_a5_bit");
      begin
        repeat (6) @(negedge clk);
        bus_read(3'd4, 32'h0, "txready_busy");
        bus_write(3'd2, 32'h0000_00FF);
        bus_read(3'd4, 32'h0, "txready_busy2");
      end
    join
    bus_read(3'd4, 32'h1, "txready_after_frame");
    for (int i = 0; i < 20; i++) begin
      checkOutput("tx_dropped_idle", {31'd0, txd}, 32'd1);
      @(negedge clk);
    end

    // DIV below 2 runs at 2 cycles per bit; the register keeps the raw value
    bus_write(3'd1, 32'h0);
    bus_read(3'd1, 32'h0, "div_raw_zero");
    bus_write(3'd2, 32'h0000_0001);
    check_frame(10'b1000000010, 2, "tx_div0_bit");
    bus_read(3'd4, 32'h1, "txready_div0");

    // RX loopback at DIV=8
    bus_write(3'd1, 32'd8);
    bus_write(3'd6, 32'h1);
    loop_en = 1'b1;
    bus_write(3'd2, 32'h0000_003C);
    repeat (100) @(negedge clk);
    bus_read(3'd7, 32'h1, "rxready_3c");
    bus_read(3'd5, 32'h3C, "rxdata_3c");
    bus_read(3'd7, 32'h0, "rxready_cleared");

    // Overrun: two bytes without reading
    bus_write(3'd2, 32'h0000_0011);
    repeat (100) @(negedge clk);
    bus_write(3'd2, 32'h0000_0022);
    repeat (100) @(negedge clk);
    bus_read(3'd7, 32'h3, "rxready_overrun");
    bus_read(3'd5, 32'h22, "rxdata_overrun");
    bus_read(3'd7, 32'h0, "rxready_after_overrun");

    // Framing error leaves the held byte and flags alone
    loop_en = 1'b0;
    drive_frame(8'h55, 1'b1, 8);
    bus_read(3'd7, 32'h1, "rxready_55");
    drive_frame(8'h99, 1'b0, 8);
    bus_read(3'd7, 32'h1, "rxready_after_framing");
    bus_read(3'd5, 32'h55, "rxdata_after_framing");
    bus_read(3'd7, 32'h0, "rxready_cleared2");

    // Glitch rejection at DIV=16, then a real frame proves RX is idle again
    bus_write(3'd1, 32'd16);
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (60) @(negedge clk);
    bus_read(3'd7, 32'h0, "rxready_glitch");
    drive_frame(8'h5A, 1'b1, 16);
    bus_read(3'd7, 32'h1, "rxready_5a");
    bus_read(3'd5, 32'h5A, "rxdata_5a");
    drive_frame(8'h77, 1'b1, 16);
    bus_read(3'd7, 32'h1, "rxready_77");

    // SOFTRESET during data bit 4 of a frame
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'h0000_00A5);
    repeat (21) @(negedge clk);
    checkOutput("txd_before_softreset", {31'd0, txd}, 32'd0);
    bus_write(3'd0, 32'h1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("txd_after_softreset", {31'd0, txd}, 32'd1);
      @(negedge clk);
    end
    bus_read(3'd4, 32'h1, "txready_softreset");
    bus_read(3'd1, 32'd4, "div_kept_softreset");
    bus_read(3'd3, 32'h1, "txen_kept_softreset");
    bus_read(3'd6, 32'h1, "rxen_kept_softreset");
    bus_read(3'd7, 32'h0, "rxready_softreset");

    // Hardware reset during data bit 4 of a frame
    bus_write(3'd2, 32'h0000_00A5);
    repeat (21) @(negedge clk);
    checkOutput("txd_before_rst", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("txd_during_rst", {31'd0, txd}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("txd_after_rst", {31'd0, txd}, 32'd1);
    bus_read(3'd4, 32'h1, "txready_rst");
    bus_read(3'd1, 32'd868, "div_rst");
    bus_read(3'd3, 32'h0, "txen_rst");
    bus_read(3'd7, 32'h0, "rxready_rst");

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_read_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
